// File: rtl/serial_seq_pkg.sv
// rtl/serial_seq_pkg.sv - shared encodings for the serial output sequencer
package serial_seq_pkg;

  localparam logic [1:0] IDLE_HIGH   = 2'b00;
  localparam logic [1:0] IDLE_LOW    = 2'b01;
  localparam logic [1:0] IDLE_KEEP   = 2'b10;
  localparam logic [1:0] IDLE_REPEAT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } seq_state_e;

  // Queue entry is {freq, idle[1:0], data}
  localparam int CMD_CTRL_BITS = 3;

  function automatic int cmd_width(input int data_bit);
    return data_bit + CMD_CTRL_BITS;
  endfunction

endpackage

// File: rtl/serial_cmd_fifo.sv
// rtl/serial_cmd_fifo.sv - synchronous command queue with push/pop/flush
module serial_cmd_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok;
  logic             pop_ok;

  assign o_full     = (level_q == LW'(DEPTH));
  assign o_empty    = (level_q == '0);
  assign o_level    = level_q;
  assign o_rdata    = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a push on full is accepted then
  assign pop_ok     = i_pop & ~o_empty & ~i_flush;
  assign push_ok    = i_push & (~o_full | pop_ok) & ~i_flush;
  assign o_overflow = i_push & o_full & ~pop_ok & ~i_flush;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/serial_out_sequencer.sv
// rtl/serial_out_sequencer.sv - queues words and dispatches them to the serial engine
module serial_out_sequencer
  import serial_seq_pkg::*;
#(
  parameter int DATA_BIT    = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_wr_en,
  input  logic [DATA_BIT-1:0]         i_wr_data,
  input  logic                        i_wr_freq,
  input  logic [1:0]                  i_wr_idle,
  input  logic                        i_run,
  input  logic                        i_abort,
  input  logic                        i_done_tick,
  output logic                        o_start,
  output logic                        o_stop,
  output logic                        o_sel_freq,
  output logic [1:0]                  o_idle_mode,
  output logic [DATA_BIT-1:0]         o_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic                        o_busy,
  output logic                        o_seq_done,
  output logic                        o_err
);

  localparam int CW = cmd_width(DATA_BIT);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  // Loaded one short so o_stop lands TIMEOUT_CYC cycles after o_start
  localparam logic [TW-1:0] WDOG_LOAD = TW'(TIMEOUT_CYC - 1);

  seq_state_e          state_q, state_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [TW-1:0]       wdog_q, wdog_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                freq_q, freq_d;
  logic [1:0]          idle_q, idle_d;
  logic                stop_q, stop_d;
  logic                seq_done_q, seq_done_d;
  logic                err_q, err_d;

  logic                pop;
  logic                flush;
  logic                word_fin;
  logic                gap_expire;
  logic [CW-1:0]       head;
  logic                fifo_ovf;

  serial_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (i_wr_en),
    .i_pop      (pop),
    .i_flush    (flush),
    .i_wdata    ({i_wr_freq, i_wr_idle, i_wr_data}),
    .o_rdata    (head),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_level    (o_level),
    .o_overflow (fifo_ovf)
  );

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    wdog_d     = wdog_q;
    data_d     = data_q;
    freq_d     = freq_q;
    idle_d     = idle_q;
    stop_d     = 1'b0;
    seq_done_d = 1'b0;
    err_d      = err_q | fifo_ovf;
    pop        = 1'b0;
    flush      = 1'b0;
    word_fin   = 1'b0;
    gap_expire = 1'b0;

    if (i_abort) begin
      flush   = 1'b1;
      state_d = ST_IDLE;
      stop_d  = (state_q == ST_START) || (state_q == ST_WAIT);
    end else begin
      case (state_q)
        ST_IDLE: begin
          pop = i_run & ~o_empty;
        end
        ST_START: begin
          wdog_d  = WDOG_LOAD;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (i_done_tick) begin
            word_fin = 1'b1;
          end else if (wdog_q <= TW'(1)) begin
            stop_d   = 1'b1;
            err_d    = 1'b1;
            word_fin = 1'b1;
          end else begin
            wdog_d = wdog_q - TW'(1);
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            gap_expire = 1'b1;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // With no gap configured, a finished word expires the gap immediately
      if (word_fin) begin
        if (GAP_CYC == 0) begin
          gap_expire = 1'b1;
        end else begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end
      end

      if (gap_expire) begin
        if (i_run && !o_empty) begin
          pop = 1'b1;
        end else begin
          state_d    = ST_IDLE;
          seq_done_d = o_empty;
        end
      end

      if (pop) begin
        state_d = ST_START;
        data_d  = head[DATA_BIT-1:0];
        idle_d  = head[CW-2 -: 2];
        freq_d  = head[CW-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      wdog_q     <= '0;
      data_q     <= '0;
      freq_q     <= 1'b0;
      idle_q     <= 2'b00;
      stop_q     <= 1'b0;
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      wdog_q     <= wdog_d;
      data_q     <= data_d;
      freq_q     <= freq_d;
      idle_q     <= idle_d;
      stop_q     <= stop_d;
      seq_done_q <= seq_done_d;
      err_q      <= err_d;
    end
  end

  assign o_start     = (state_q == ST_START);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_stop      = stop_q;
  assign o_sel_freq  = freq_q;
  assign o_idle_mode = idle_q;
  assign o_data      = data_q;
  assign o_seq_done  = seq_done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_serial_out_sequencer.sv
// tb/tb_serial_out_sequencer.sv - directed self-checking bench for serial_out_sequencer
module tb_serial_out_sequencer;

  logic        clk;
  logic        rst_n;
  logic        i_wr_en;
  logic [15:0] i_wr_data;
  logic        i_wr_freq;
  logic [1:0]  i_wr_idle;
  logic        i_run;
  logic        i_abort;
  logic        i_done_tick;
  logic        o_start;
  logic        o_stop;
  logic        o_sel_freq;
  logic [1:0]  o_idle_mode;
  logic [15:0] o_data;
  logic        o_full;
  logic        o_empty;
  logic [3:0]  o_level;
  logic        o_busy;
  logic        o_seq_done;
  logic        o_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic auto_done = 1'b0;

  int          n_start   = 0;
  int          n_stop    = 0;
  int          n_seqdone = 0;
  int          sd_cyc    = 0;
  logic [15:0] st_data [$];
  logic        st_freq [$];
  logic [1:0]  st_idle [$];
  int          st_cyc  [$];
  int          dn_cyc  [$];

  serial_out_sequencer #(
    .DATA_BIT    (16),
    .FIFO_DEPTH  (8),
    .GAP_CYC     (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (i_wr_en),
    .i_wr_data   (i_wr_data),
    .i_wr_freq   (i_wr_freq),
    .i_wr_idle   (i_wr_idle),
    .i_run       (i_run),
    .i_abort     (i_abort),
    .i_done_tick (i_done_tick),
    .o_start     (o_start),
    .o_stop      (o_stop),
    .o_sel_freq  (o_sel_freq),
    .o_idle_mode (o_idle_mode),
    .o_data      (o_data),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_level     (o_level),
    .o_busy      (o_busy),
    .o_seq_done  (o_seq_done),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_start) begin
      n_start <= n_start + 1;
      st_data.push_back(o_data);
      st_freq.push_back(o_sel_freq);
      st_idle.push_back(o_idle_mode);
      st_cyc.push_back(cyc);
    end
    if (o_stop) n_stop <= n_stop + 1;
    if (o_seq_done) begin
      n_seqdone <= n_seqdone + 1;
      sd_cyc    <= cyc;
    end
  end

  // Engine model: done tick 40 clocks after each start
  initial begin
    i_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (o_start && auto_done) begin
        repeat (39) @(negedge clk);
        i_done_tick = 1'b1;
        dn_cyc.push_back(cyc);
        @(negedge clk);
        i_done_tick = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic f, input logic [1:0] m);
    i_wr_en   = 1'b1;
    i_wr_data = d;
    i_wr_freq = f;
    i_wr_idle = m;
    @(negedge clk);
    i_wr_en   = 1'b0;
  endtask

  initial begin
    int k;
    int sb;
    int db;
    int ns;
    int nst;
    int nq;
    int rc;
    int s;
    int s2;
    logic [15:0] w;

    rst_n = 1'b0; i_wr_en = 1'b0; i_wr_data = '0; i_wr_freq = 1'b0;
    i_wr_idle = 2'b00; i_run = 1'b0; i_abort = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_start", 32'(o_start), 0);
    check("rst_stop", 32'(o_stop), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_empty", 32'(o_empty), 1);
    check("rst_full", 32'(o_full), 0);
    check("rst_level", 32'(o_level), 0);
    check("rst_err", 32'(o_err), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_seq_done", 32'(o_seq_done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // three words back-to-back, gap timing
    push(16'hA5A5, 1'b1, 2'b01);
    push(16'h1234, 1'b0, 2'b00);
    push(16'hFFFF, 1'b1, 2'b10);
    check("t1_level", 32'(o_level), 3);
    sb = st_data.size(); db = dn_cyc.size(); ns = n_start; nst = n_stop; nq = n_seqdone;
    auto_done = 1'b1;
    i_run = 1'b1;
    rc = cyc;
    k = 0;
    while (n_seqdone == nq && k < 600) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    check("t1_seq_done_count", 32'(n_seqdone - nq), 1);
    check("t1_start_count", 32'(n_start - ns), 3);
    check("t1_first_latency", 32'(st_cyc[sb]), 32'(rc + 1));
    check("t1_data0", 32'(st_data[sb]), 32'hA5A5);
    check("t1_freq0", 32'(st_freq[sb]), 1);
    check("t1_idle0", 32'(st_idle[sb]), 1);
    check("t1_data1", 32'(st_data[sb+1]), 32'h1234);
    check("t1_freq1", 32'(st_freq[sb+1]), 0);
    check("t1_idle1", 32'(st_idle[sb+1]), 0);
    check("t1_data2", 32'(st_data[sb+2]), 32'hFFFF);
    check("t1_freq2", 32'(st_freq[sb+2]), 1);
    check("t1_idle2", 32'(st_idle[sb+2]), 2);
    check("t2_gap_word1", 32'(st_cyc[sb+1]), 32'(dn_cyc[db] + 5));
    check("t2_gap_word2", 32'(st_cyc[sb+2]), 32'(dn_cyc[db+1] + 5));
    check("t1_seq_done_cyc", 32'(sd_cyc), 32'(dn_cyc[db+2] + 5));
    check("t1_hold_data", 32'(o_data), 32'hFFFF);
    check("t1_hold_idle", 32'(o_idle_mode), 2);
    check("t1_idle_busy", 32'(o_busy), 0);
    check("t1_no_stop", 32'(n_stop - nst), 0);
    i_run = 1'b0;

    // abort during the second of five words
    ns = n_start; nst = n_stop; nq = n_seqdone;
    for (int i = 0; i < 5; i++) begin
      w = 16'h0300 + 16'(i);
      push(w, w[0], w[1:0]);
    end
    i_run = 1'b1;
    k = 0;
    while ((n_start - ns) < 2 && k < 300) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    check("t4_busy_before", 32'(o_busy), 1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("t4_stop", 32'(o_stop), 1);
    check("t4_level", 32'(o_level), 0);
    check("t4_empty", 32'(o_empty), 1);
    check("t4_busy", 32'(o_busy), 0);
    check("t4_hold_data", 32'(o_data), 32'h0301);
    @(negedge clk);
    check("t4_stop_single", 32'(o_stop), 0);
    repeat (100) @(negedge clk);
    check("t4_start_count", 32'(n_start - ns), 2);
    check("t4_stop_count", 32'(n_stop - nst), 1);
    check("t4_no_seq_done", 32'(n_seqdone - nq), 0);
    check("t4_err", 32'(o_err), 0);
    i_run = 1'b0;

    // watchdog timeout, no done ticks
    auto_done = 1'b0;
    push(16'hBEEF, 1'b0, 2'b11);
    push(16'hCAFE, 1'b1, 2'b01);
    i_run = 1'b1;
    k = 0;
    while (!o_start && k < 20) begin @(negedge clk); k++; end
    s = cyc;
    check("t5_start1", 32'(o_start), 1);
    check("t5_data1", 32'(o_data), 32'hBEEF);
    @(negedge clk);
    k = 0;
    while (!o_stop && k < 200) begin @(negedge clk); k++; end
    check("t5_timeout_cyc", 32'(cyc - s), 100);
    check("t5_err", 32'(o_err), 1);
    @(negedge clk);
    k = 0;
    while (!o_start && k < 20) begin @(negedge clk); k++; end
    check("t5_next_start_cyc", 32'(cyc - s), 104);
    check("t5_data2", 32'(o_data), 32'hCAFE);
    check("t5_freq2", 32'(o_sel_freq), 1);
    @(negedge clk);
    k = 0;
    while (!o_stop && k < 200) begin @(negedge clk); k++; end
    s2 = cyc;
    @(negedge clk);
    k = 0;
    while (!o_seq_done && k < 20) begin @(negedge clk); k++; end
    check("t5_seq_done_cyc", 32'(cyc - s2), 4);
    check("t5_busy_after", 32'(o_busy), 0);
    i_run = 1'b0;

    // push on full with pop, then reset mid-word
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_err_cleared", 32'(o_err), 0);
    for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i), 1'b1, 2'b11);
    check("t6_full", 32'(o_full), 1);
    check("t6_level_full", 32'(o_level), 8);
    i_run = 1'b1;
    i_wr_en = 1'b1; i_wr_data = 16'h0777; i_wr_freq = 1'b0; i_wr_idle = 2'b00;
    @(negedge clk);
    i_wr_en = 1'b0;
    check("t6_level_same", 32'(o_level), 8);
    check("t6_no_err", 32'(o_err), 0);
    check("t6_start", 32'(o_start), 1);
    check("t6_data", 32'(o_data), 32'h0200);
    repeat (5) @(negedge clk);
    check("t6_busy_wait", 32'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(o_busy), 0);
    check("t6_rst_data", 32'(o_data), 0);
    check("t6_rst_freq", 32'(o_sel_freq), 0);
    check("t6_rst_idle", 32'(o_idle_mode), 0);
    check("t6_rst_level", 32'(o_level), 0);
    check("t6_rst_empty", 32'(o_empty), 1);
    check("t6_rst_full", 32'(o_full), 0);
    i_run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // overflow: nine pushes into depth eight, then drain
    for (int i = 0; i < 8; i++) begin
      w = 16'h0100 + 16'(i);
      push(w, w[0], w[1:0]);
    end
    check("t3_err_at_8", 32'(o_err), 0);
    check("t3_full_at_8", 32'(o_full), 1);
    push(16'h0108, 1'b1, 2'b11);
    check("t3_err_at_9", 32'(o_err), 1);
    check("t3_level", 32'(o_level), 8);
    check("t3_full", 32'(o_full), 1);
    sb = st_data.size(); ns = n_start; nq = n_seqdone;
    auto_done = 1'b1;
    i_run = 1'b1;
    k = 0;
    while (n_seqdone == nq && k < 1000) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    check("t3_start_count", 32'(n_start - ns), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_word%0d", i), 32'(st_data[sb+i]), 32'h0100 + 32'(i));
    end
    check("t3_freq7", 32'(st_freq[sb+7]), 1);
    check("t3_idle6", 32'(st_idle[sb+6]), 2);
    check("t3_empty", 32'(o_empty), 1);
    check("t3_err_sticky", 32'(o_err), 1);
    i_run = 1'b0;
    auto_done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
